// File: rtl/vector_lane_serializer.sv
// Serializes one 256-bit vector (plus packed per-lane NZCV flags) into 32-bit lane beats selected by a lane mask.
// Optional flag path is built only when VSER_FLAGS_EN is defined; otherwise out_flags is tied to zero.
module vector_lane_serializer #(
  parameter int N = 32,
  parameter int V = 256,
  localparam int LANES = V / N,
  localparam int LW = $clog2(LANES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [V-1:0]       in_vec,
  input  logic [4*LANES-1:0] in_flags,
  input  logic [LANES-1:0]   in_mask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_data,
  output logic [3:0]         out_flags,
  output logic [LW-1:0]      out_lane,
  output logic               out_last,
  output logic               busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // Lowest enabled lane whose index is at least 'from'; 'from' may be LANES.
  function automatic logic [LW-1:0] lowest_from(input logic [LANES-1:0] mask, input logic [LW:0] from);
    logic [LW-1:0] idx;
    idx = {LW{1'b0}};
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) idx = LW'(i);
    end
    return idx;
  endfunction

  function automatic logic none_above(input logic [LANES-1:0] mask, input logic [LW-1:0] lane);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i] && (i > int'(lane))) hit = 1'b1;
    end
    return !hit;
  endfunction

  logic [0:0]       state_r;
  logic [V-1:0]     buf_vec_r;
  logic [LANES-1:0] buf_mask_r;
  logic             out_valid_r;
  logic [N-1:0]     out_data_r;
  logic [LW-1:0]    lane_r;
  logic             out_last_r;

  logic             accept_s;
  logic             launch_s;
  logic             advance_s;
  logic             finish_s;
  logic [LW-1:0]    first_lane_s;
  logic             first_last_s;
  logic [LW-1:0]    next_lane_s;
  logic             next_last_s;

  // Handshake decode and lane-walk lookahead; only registered state feeds the outputs.
  always_comb begin
    accept_s     = (state_r == IDLE) && in_valid;
    launch_s     = accept_s && (in_mask != {LANES{1'b0}});
    advance_s    = (state_r == SEND) && out_ready && !out_last_r;
    finish_s     = (state_r == SEND) && out_ready && out_last_r;
    first_lane_s = lowest_from(in_mask, {(LW + 1){1'b0}});
    first_last_s = none_above(in_mask, first_lane_s);
    next_lane_s  = lowest_from(buf_mask_r, {1'b0, lane_r} + (LW + 1)'(1));
    next_last_s  = none_above(buf_mask_r, next_lane_s);
  end

  // FSM, vector buffers and registered beat outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      buf_vec_r   <= {V{1'b0}};
      buf_mask_r  <= {LANES{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {N{1'b0}};
      lane_r      <= {LW{1'b0}};
      out_last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            buf_vec_r  <= in_vec;
            buf_mask_r <= in_mask;
          end else begin
            buf_vec_r  <= buf_vec_r;
            buf_mask_r <= buf_mask_r;
          end
          // An all-zero mask is accepted and dropped without leaving IDLE.
          if (launch_s) begin
            state_r     <= SEND;
            out_valid_r <= 1'b1;
            lane_r      <= first_lane_s;
            out_data_r  <= in_vec[N*first_lane_s +: N];
            out_last_r  <= first_last_s;
          end else begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        SEND: begin
          if (finish_s) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end else if (advance_s) begin
            lane_r     <= next_lane_s;
            out_data_r <= buf_vec_r[N*next_lane_s +: N];
            out_last_r <= next_last_s;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef VSER_FLAGS_EN
  logic [4*LANES-1:0] buf_flags_r;
  logic [3:0]         out_flags_r;

  // Flag buffer and flag output follow the same accept/advance events as the data path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_flags_r <= {(4*LANES){1'b0}};
      out_flags_r <= 4'b0000;
    end else if (launch_s) begin
      buf_flags_r <= in_flags;
      out_flags_r <= in_flags[4*first_lane_s +: 4];
    end else if (accept_s) begin
      buf_flags_r <= in_flags;
    end else if (advance_s) begin
      out_flags_r <= buf_flags_r[4*next_lane_s +: 4];
    end else begin
      out_flags_r <= out_flags_r;
    end
  end

  assign out_flags = out_flags_r;
`else
  logic unused_flags_s;
  assign unused_flags_s = ^in_flags;
  assign out_flags      = 4'b0000;
`endif

  assign in_ready  = rst_n && (state_r == IDLE);
  assign busy      = (state_r == SEND);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_lane  = lane_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_vector_lane_serializer.sv
// Directed plus randomized bench for vector_lane_serializer; expected beats come from a queue of enabled lanes.
module tb_vector_lane_serializer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] in_vec = '0;
  logic [31:0]  in_flags = '0;
  logic [7:0]   in_mask = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic [3:0]   out_flags;
  logic [2:0]   out_lane;
  logic         out_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  vector_lane_serializer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .in_flags(in_flags), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags), .out_lane(out_lane),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_flags(input logic [31:0] f, input int lane);
`ifdef VSER_FLAGS_EN
    return f[4*lane +: 4];
`else
    return 4'b0000;
`endif
  endfunction

  // Offers one vector at a negedge and checks every beat; stalls stall_cycles extra cycles on stall_lane;
  // returns early (beat abort_at presented) when abort_at >= 0.
  task automatic send(input logic [255:0] v, input logic [31:0] f, input logic [7:0] m,
                      input int stall_lane, input int stall_cycles, input int abort_at);
    int lanes[$];
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 8; i++) if (m[i]) lanes.push_back(i);
    in_valid = 1'b1; in_vec = v; in_flags = f; in_mask = m; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_vec = {8{$urandom()}}; in_flags = $urandom(); in_mask = 8'($urandom());
    if (lanes.size() == 0) begin
      chk("empty_out_valid", 64'(out_valid), 64'd0);
      chk("empty_busy", 64'(busy), 64'd0);
      chk("empty_in_ready", 64'(in_ready), 64'd1);
      return;
    end
    for (int k = 0; k < lanes.size(); k++) begin
      int l;
      l = lanes[k];
      if (k == abort_at) return;
      for (int s = 0; s <= ((l == stall_lane) ? stall_cycles : 0); s++) begin
        out_ready = (l == stall_lane && s < stall_cycles) ? 1'b0 : 1'b1;
        chk("beat_valid", 64'(out_valid), 64'd1);
        chk("beat_lane", 64'(out_lane), 64'(l));
        chk("beat_data", 64'(out_data), 64'(v[32*l +: 32]));
        chk("beat_flags", 64'(out_flags), 64'(exp_flags(f, l)));
        chk("beat_last", 64'(out_last), 64'(k == lanes.size() - 1));
        chk("beat_in_ready", 64'(in_ready), 64'd0);
        chk("beat_busy", 64'(busy), 64'd1);
        @(negedge clk);
      end
    end
    out_ready = 1'b1;
    chk("done_out_valid", 64'(out_valid), 64'd0);
    chk("done_in_ready", 64'(in_ready), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
  endtask

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    logic [255:0] ramp;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    chk("rst_out_lane", 64'(out_lane), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    for (int i = 0; i < 8; i++) ramp[32*i +: 32] = 32'(32'h1111_1111 * i);
    send(ramp, 32'h7654_3210, 8'hFF, -1, 0, -1);              // full burst + flags
    send(rand_vec(), $urandom(), 8'h81, -1, 0, -1);           // sparse mask
    send(rand_vec(), $urandom(), 8'h00, -1, 0, -1);           // empty mask
    send(rand_vec(), 32'h7654_3210, 8'hFF, 2, 3, -1);         // backpressure on lane 2

    // Reset after the lane 3 transfer, then a single-lane vector.
    send(rand_vec(), $urandom(), 8'hFF, -1, 0, 4);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_replay", 64'(out_valid), 64'd0);
    send(rand_vec(), $urandom(), 8'h10, -1, 0, -1);

    for (int t = 0; t < 20; t++) begin
      send(rand_vec(), $urandom(), 8'($urandom()), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 3)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
